pixel_array_ctrl: RTL and testbench

//  Frame sequencer for pixel_array. On start, runs erase -> optional CDS reset-level conversion ->

---
 rtl/pixel_ctrl_pkg.sv | 21 ++
 rtl/phase_timer.sv | 27 ++
 rtl/pixel_array_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_pixel_array_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_ctrl_pkg.sv
// Shared types and helpers for the pixel_array frame sequencer.
package pixel_ctrl_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StErase,
    StCorrConv,
    StExpose,
    StDataClr,
    StDataConv,
    StReadSel,
    StReadOut,
    StDone
  } state_t;

  // Full ramp length: counter climbs from 0 to its maximum without wrapping.
  function automatic int unsigned conv_cycles(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter shared by every timed phase; done marks the last cycle of a phase.
module phase_timer #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  // A phase loaded with N stays for N cycles: the counter reads N..1 while in it.
  assign done_o = (cnt_q == Width'(1));

endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for pixel_array: erase, optional CDS reset conversion, exposure,
// data conversion, then per-pixel readout onto a valid/ready stream.
module pixel_array_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int unsigned PIXEL_COUNT   = 4,
  parameter int unsigned COUNTER_WIDTH = 8,
  parameter int unsigned ERASE_CYCLES  = 5,
  parameter int unsigned EXPOSE_W      = 16,
  localparam int unsigned SEL_W        = $clog2(PIXEL_COUNT)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     cds_en,
  input  logic [EXPOSE_W-1:0]      expose_cycles,
  input  logic [COUNTER_WIDTH-1:0] pixel_out,
  output logic                     arr_reset,
  output logic                     erase,
  output logic                     corr,
  output logic                     expose,
  output logic                     convert,
  output logic                     cds,
  output logic                     read,
  output logic [SEL_W-1:0]         pixel_select,
  output logic [COUNTER_WIDTH-1:0] out_data,
  output logic [SEL_W-1:0]         out_index,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int unsigned CONV_CYCLES = conv_cycles(COUNTER_WIDTH);
  localparam int unsigned TimerW = (EXPOSE_W > COUNTER_WIDTH) ? EXPOSE_W : COUNTER_WIDTH;
  localparam logic [SEL_W-1:0] LastIdx = SEL_W'(PIXEL_COUNT - 1);

  state_t              state_q;
  logic [EXPOSE_W-1:0] expose_len_q;
  logic [SEL_W-1:0]    idx_q;

  logic              timer_load;
  logic [TimerW-1:0] timer_val;
  logic              timer_done;

  // Load the timer on the same edge that enters each timed phase.
  always_comb begin
    timer_load = 1'b0;
    timer_val  = '0;
    case (state_q)
      StIdle: begin
        if (start) begin
          timer_load = 1'b1;
          timer_val  = TimerW'(ERASE_CYCLES);
        end
      end
      StErase: begin
        if (timer_done) begin
          timer_load = 1'b1;
          timer_val  = cds ? TimerW'(CONV_CYCLES) : TimerW'(expose_len_q);
        end
      end
      StCorrConv: begin
        if (timer_done) begin
          timer_load = 1'b1;
          timer_val  = TimerW'(expose_len_q);
        end
      end
      StDataClr: begin
        timer_load = 1'b1;
        timer_val  = TimerW'(CONV_CYCLES);
      end
      default: ;
    endcase
  end

  phase_timer #(
    .Width(TimerW)
  ) u_phase_timer (
    .clk_i     (clk),
    .reset_i   (reset),
    .load_i    (timer_load),
    .load_val_i(timer_val),
    .done_o    (timer_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      expose_len_q <= '0;
      idx_q        <= '0;
      arr_reset    <= 1'b0;
      erase        <= 1'b0;
      corr         <= 1'b0;
      expose       <= 1'b0;
      convert      <= 1'b0;
      cds          <= 1'b0;
      read         <= 1'b0;
      pixel_select <= '0;
      out_data     <= '0;
      out_index    <= '0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q      <= StErase;
            busy         <= 1'b1;
            erase        <= 1'b1;
            arr_reset    <= 1'b1;
            cds          <= cds_en;
            expose_len_q <= (expose_cycles == '0) ? EXPOSE_W'(1) : expose_cycles;
            idx_q        <= '0;
          end
        end
        StErase: begin
          if (timer_done) begin
            erase     <= 1'b0;
            arr_reset <= 1'b0;
            if (cds) begin
              state_q <= StCorrConv;
              corr    <= 1'b1;
              convert <= 1'b1;
            end else begin
              state_q <= StExpose;
              expose  <= 1'b1;
            end
          end
        end
        StCorrConv: begin
          if (timer_done) begin
            state_q <= StExpose;
            corr    <= 1'b0;
            convert <= 1'b0;
            expose  <= 1'b1;
          end
        end
        StExpose: begin
          if (timer_done) begin
            state_q   <= StDataClr;
            expose    <= 1'b0;
            arr_reset <= 1'b1;
          end
        end
        StDataClr: begin
          state_q   <= StDataConv;
          arr_reset <= 1'b0;
          convert   <= 1'b1;
        end
        StDataConv: begin
          if (timer_done) begin
            state_q      <= StReadSel;
            convert      <= 1'b0;
            read         <= 1'b1;
            idx_q        <= '0;
            pixel_select <= '0;
          end
        end
        StReadSel: begin
          // pixel_out has had a full cycle to settle on the selected pixel.
          state_q   <= StReadOut;
          out_data  <= pixel_out;
          out_index <= idx_q;
          out_valid <= 1'b1;
        end
        StReadOut: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx_q == LastIdx) begin
              state_q      <= StDone;
              read         <= 1'b0;
              pixel_select <= '0;
              frame_done   <= 1'b1;
            end else begin
              state_q      <= StReadSel;
              idx_q        <= idx_q + SEL_W'(1);
              pixel_select <= idx_q + SEL_W'(1);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          cds     <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Directed, table-driven bench for pixel_array_ctrl with a behavioural pixel source.
module tb_pixel_array_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        cds_en = 1'b0;
  logic [15:0] expose_cycles = '0;
  logic [7:0]  pixel_out;
  logic        arr_reset, erase, corr, expose, convert, cds, read;
  logic [1:0]  pixel_select;
  logic [7:0]  out_data;
  logic [1:0]  out_index;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy, frame_done;

  logic [7:0]  pix_base = 8'h00;
  logic [7:0]  pix_noise = 8'h00;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Pixel value depends on the selected pixel; noise perturbs it while a read stalls.
  assign pixel_out = pix_base + pix_noise + 8'(pixel_select) * 8'd37;

  pixel_array_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cds_en       (cds_en),
    .expose_cycles(expose_cycles),
    .pixel_out    (pixel_out),
    .arr_reset    (arr_reset),
    .erase        (erase),
    .corr         (corr),
    .expose       (expose),
    .convert      (convert),
    .cds          (cds),
    .read         (read),
    .pixel_select (pixel_select),
    .out_data     (out_data),
    .out_index    (out_index),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  typedef struct {
    logic        cds;
    logic [15:0] x;
    int          stall_pix;
    int          stall_len;
    logic [7:0]  base;
    int          exp_busy;
    int          exp_expose;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [21:0] all_outs();
    return {arr_reset, erase, corr, expose, convert, cds, read, pixel_select,
            out_data, out_index, out_valid, busy, frame_done};
  endfunction

  task automatic run_frame(input string tag, input vec_t v);
    int busy_n = 0, erase_n = 0, arst_n = 0, corr_n = 0, expose_n = 0;
    int conv_n = 0, conv_runs = 0, conv_run = 0, conv_max = 0, fd_n = 0;
    int cds_bad = 0, excl_bad = 0, stall_bad = 0, stall_n = 0, got_n = 0, order_bad = 0;
    int last_corr = -1, first_expose = -1, idle_bad = 0;
    logic prev_conv = 1'b0;
    logic [7:0] held = '0;
    logic [7:0] exp_d;
    bit done = 1'b0;
    pix_base = v.base;
    @(negedge clk);
    cds_en = v.cds;
    expose_cycles = v.x;
    out_ready = 1'b1;
    start = 1'b1;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      pix_noise = 8'h00;
      if (cyc == 0) begin
        cds_en = !v.cds;
        expose_cycles = 16'd999;
      end
      if (cyc == 20) start = 1'b1;
      if (!busy) begin
        done = 1'b1;
      end else begin
        busy_n++;
        erase_n += int'(erase);
        arst_n += int'(arr_reset);
        if (corr) begin
          corr_n++;
          last_corr = cyc;
          if (!convert) excl_bad++;
        end
        if (expose) begin
          expose_n++;
          if (first_expose < 0) first_expose = cyc;
        end
        if (convert) begin
          conv_n++;
          if (!prev_conv) conv_runs++;
          conv_run++;
          if (conv_run > conv_max) conv_max = conv_run;
        end else begin
          conv_run = 0;
        end
        prev_conv = convert;
        if (int'(erase) + int'(expose) + int'(convert) + int'(read) > 1) excl_bad++;
        if (arr_reset && !erase && (expose || convert || read)) excl_bad++;
        if (cds != v.cds) cds_bad++;
        if (frame_done) begin
          fd_n++;
          start = 1'b1;
        end
        if (out_valid && out_index == v.stall_pix && stall_n < v.stall_len) begin
          if (stall_n == 0) held = out_data;
          else if (out_data != held || !read || pixel_select != out_index) stall_bad++;
          stall_n++;
          out_ready = 1'b0;
          pix_noise = 8'h5a;
        end else begin
          out_ready = 1'b1;
          if (out_valid) begin
            exp_d = v.base + 8'(got_n * 37);
            if (out_index != 2'(got_n) || out_data != exp_d || got_n > 3) order_bad++;
            got_n++;
          end
        end
      end
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy || cds || out_valid || read || erase || expose || convert) idle_bad++;
    end
    chk({tag, "_terminated"}, int'(done), 1);
    chk({tag, "_busy_cycles"}, busy_n, v.exp_busy);
    chk({tag, "_erase_cycles"}, erase_n, 5);
    chk({tag, "_arr_reset_cycles"}, arst_n, 6);
    chk({tag, "_corr_cycles"}, corr_n, v.cds ? 255 : 0);
    chk({tag, "_expose_cycles"}, expose_n, v.exp_expose);
    chk({tag, "_convert_cycles"}, conv_n, v.cds ? 510 : 255);
    chk({tag, "_convert_run_max"}, conv_max, 255);
    chk({tag, "_convert_runs"}, conv_runs, v.cds ? 2 : 1);
    chk({tag, "_frame_done"}, fd_n, 1);
    chk({tag, "_pixels"}, got_n, 4);
    chk({tag, "_pixel_order_data"}, order_bad, 0);
    chk({tag, "_phase_exclusive"}, excl_bad, 0);
    chk({tag, "_cds_level"}, cds_bad, 0);
    chk({tag, "_stall_cycles"}, stall_n, v.stall_len);
    chk({tag, "_stall_stable"}, stall_bad, 0);
    chk({tag, "_idle_after"}, idle_bad, 0);
    if (v.cds) chk({tag, "_corr_before_expose"}, int'(first_expose > last_corr), 1);
  endtask

  vec_t vecs[5];

  initial begin
    int bad;
    vecs[0] = '{cds: 1'b0, x: 16'd10, stall_pix: -1, stall_len: 0, base: 8'h10,
                exp_busy: 280, exp_expose: 10};
    vecs[1] = '{cds: 1'b1, x: 16'd10, stall_pix: -1, stall_len: 0, base: 8'h55,
                exp_busy: 535, exp_expose: 10};
    vecs[2] = '{cds: 1'b0, x: 16'd10, stall_pix: 2, stall_len: 7, base: 8'h21,
                exp_busy: 287, exp_expose: 10};
    vecs[3] = '{cds: 1'b0, x: 16'd0, stall_pix: -1, stall_len: 0, base: 8'hA0,
                exp_busy: 271, exp_expose: 1};
    vecs[4] = '{cds: 1'b1, x: 16'd3, stall_pix: 0, stall_len: 2, base: 8'hC3,
                exp_busy: 530, exp_expose: 3};

    // Reset held three cycles, then idle with start low.
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", int'(all_outs()), 0);
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (all_outs() != '0) bad++;
    end
    chk("idle_without_start", bad, 0);

    foreach (vecs[i]) run_frame($sformatf("vec%0d", i), vecs[i]);

    // Reset during DATA_CONV.
    @(negedge clk);
    cds_en = 1'b0;
    expose_cycles = 16'd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 200 && !convert; k++) @(negedge clk);
    chk("dataconv_reached", int'(convert), 1);
    repeat (40) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_dataconv_zero", int'(all_outs()), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_dataconv_idle", int'(busy), 0);
    run_frame("after_rst_a", vecs[0]);

    // Reset during a READ_OUT stall.
    @(negedge clk);
    out_ready = 1'b0;
    cds_en = 1'b0;
    expose_cycles = 16'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 600 && !out_valid; k++) @(negedge clk);
    chk("stall_reached", int'(out_valid), 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_stall_zero", int'(all_outs()), 0);
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_stall_idle", int'({busy, out_valid}), 0);
    run_frame("after_rst_b", vecs[2]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
